decoder_scan: RTL

DECODER_SCAN -- requirements
Module: decoder_scan

---
 rtl/decoder_pkg.sv | 28 ++
 rtl/dwell_timer.sv | 38 +++
 rtl/decoder_scan.sv | 92 +++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the scanning one-hot decoder: mode/direction
// encodings and a width-generic one-hot helper.
package decoder_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Widest index supported; callers cast the result down to their OUT_W.
  localparam int unsigned MAX_SEL_W = 8;
  localparam int unsigned ONEHOT_W  = 2 ** MAX_SEL_W;

  typedef logic [ONEHOT_W-1:0] onehot_t;

  function automatic onehot_t onehot(input logic [MAX_SEL_W-1:0] i);
    onehot_t v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while run is high, pulses tick
// combinationally on the terminal count and wraps to 0.
module dwell_timer #(
  parameter int unsigned DWELL = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam logic [31:0] LAST = 32'(DWELL - 1);

  logic [31:0] cnt_q, cnt_d;

  assign tick = run && !clr && (cnt_q == LAST);

  // Next count: clear dominates, otherwise advance and wrap on the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + 32'd1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_scan.sv
// One-hot decoder with direct select and timed auto-scan modes.
// All outputs are registered; out always reflects onehot(idx) when enabled.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned OUT_W      = 2 ** SEL_W,
  parameter int unsigned DWELL      = 50_000_000,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] out,
  output logic [SEL_W-1:0] idx,
  output logic             step
);

  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             step_q, step_d;
  logic             mode_prev_q;
  logic             fresh_q;
  logic             run, clr, tick;

  dwell_timer #(
    .DWELL (DWELL)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .clr  (clr),
    .tick (tick)
  );

  // Next index/step and timer control. A scan start (mode rise, or the first
  // enabled cycle after reset) clears the timer without advancing, so the
  // first advance always lands DWELL cycles after the start.
  always_comb begin
    idx_d  = idx_q;
    step_d = 1'b0;
    run    = 1'b0;
    clr    = 1'b0;
    if (en) begin
      if (mode == MODE_DIRECT || mode_prev_q == MODE_DIRECT) begin
        idx_d = sel;
        clr   = 1'b1;
      end else if (fresh_q) begin
        clr   = 1'b1;
      end else begin
        run = 1'b1;
        if (tick) begin
          step_d = 1'b1;
          idx_d  = (dir == DIR_DOWN) ? idx_q - SEL_W'(1) : idx_q + SEL_W'(1);
        end
      end
    end
    out_d = en ? OUT_W'(onehot(MAX_SEL_W'(idx_d))) : '0;
    out_d = out_d ^ {OUT_W{ACTIVE_LOW}};
  end

  // Output and scan state registers; reset dominates everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      step_q  <= 1'b0;
      out_q   <= {OUT_W{ACTIVE_LOW}};
      fresh_q <= 1'b1;
    end else begin
      idx_q  <= idx_d;
      step_q <= step_d;
      out_q  <= out_d;
      if (en) begin
        fresh_q <= 1'b0;
      end
    end
  end

  // Previous-cycle mode for rising-edge detection; tracks mode even in reset
  // so a release with mode held high does not look like a mode rise.
  always_ff @(posedge clk) begin
    mode_prev_q <= mode;
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign step = step_q;

endmodule
